// File: rtl/vec_isa_pkg.sv
// Shared ISA constants for the custom-0x5B vector/VMAC space, plus the
// descriptor validity rule and the word encoder used by vec_insn_encoder.
package vec_isa_pkg;

  localparam logic [6:0] OPC_CUSTOM = 7'b1011011;
  localparam logic [2:0] F3_VMAC    = 3'b001;
  localparam logic [2:0] F3_VEC     = 3'b010;

  localparam logic [4:0] VOP_VADD     = 5'b00000;
  localparam logic [4:0] VOP_VSUB     = 5'b00001;
  localparam logic [4:0] VOP_VMUL     = 5'b00010;
  localparam logic [4:0] VOP_VLD      = 5'b00100;
  localparam logic [4:0] VOP_VST      = 5'b00101;
  localparam logic [4:0] VOP_VMOV_S2V = 5'b01000;
  localparam logic [4:0] VOP_VMOV_V2S = 5'b01001;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;

  localparam logic KIND_VEC  = 1'b0;
  localparam logic KIND_VMAC = 1'b1;

  typedef enum logic [2:0] {
    VEC_VADD     = 3'b000,
    VEC_VSUB     = 3'b001,
    VEC_VMUL     = 3'b010,
    VEC_VLD      = 3'b011,
    VEC_VST      = 3'b100,
    VEC_VMOV_S2V = 3'b101,
    VEC_VMOV_V2S = 3'b110,
    VEC_RSVD     = 3'b111
  } vec_op_e;

  function automatic logic [4:0] vop5(input logic [2:0] op);
    logic [4:0] code;
    case (vec_op_e'(op))
      VEC_VADD:     code = VOP_VADD;
      VEC_VSUB:     code = VOP_VSUB;
      VEC_VMUL:     code = VOP_VMUL;
      VEC_VLD:      code = VOP_VLD;
      VEC_VST:      code = VOP_VST;
      VEC_VMOV_S2V: code = VOP_VMOV_S2V;
      VEC_VMOV_V2S: code = VOP_VMOV_V2S;
      default:      code = 5'b00000;
    endcase
    return code;
  endfunction

  // Reserved vector op, reserved SEW, or VMAC with op[2] set has no encoding.
  function automatic logic cmd_invalid(input logic kind, input logic [2:0] op,
                                       input logic [1:0] sew);
    logic bad;
    if (kind == KIND_VMAC) begin
      bad = op[2];
    end else begin
      bad = (op == 3'b111) || (sew == 2'b11);
    end
    return bad;
  endfunction

  function automatic logic [31:0] encode(input logic kind, input logic [2:0] op,
                                         input logic [1:0] sew, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
    logic [6:0] funct7;
    logic [2:0] funct3;
    if (kind == KIND_VMAC) begin
      funct7 = {5'b00000, op[1:0]};
      funct3 = F3_VMAC;
    end else begin
      funct7 = {sew, vop5(op)};
      funct3 = F3_VEC;
    end
    return {funct7, rs2, rs1, funct3, rd, OPC_CUSTOM};
  endfunction

endpackage

// File: rtl/insn_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented on rdata whenever
// the FIFO is non-empty; rdata reads zero while empty.
module insn_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          push_s;
  logic          pop_s;

  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign full   = (level_r == LW'(DEPTH));
  assign empty  = (level_r == LW'(0));
  assign level  = level_r;
  assign rdata  = empty ? W'(0) : mem_r[rd_ptr_r];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; pointer wrap relies on DEPTH being a power of 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/vec_insn_encoder.sv
// Expands vector/VMAC command descriptors into bursts of custom-0x5B
// instruction words, queued through a show-ahead FIFO to the consumer.
module vec_insn_encoder
  import vec_isa_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_kind,
  input  logic [2:0]         cmd_op,
  input  logic [1:0]         cmd_sew,
  input  logic [4:0]         cmd_rd,
  input  logic [4:0]         cmd_rs1,
  input  logic [4:0]         cmd_rs2,
  input  logic [2:0]         cmd_inc,
  input  logic [COUNT_W-1:0] cmd_count,
  output logic               cmd_err,
  output logic               insn_valid,
  input  logic               insn_ready,
  output logic [31:0]        insn,
  output logic               insn_last,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  state_e               state_r;
  logic                 kind_r;
  logic [2:0]           op_r;
  logic [1:0]           sew_r;
  logic [4:0]           rd_r;
  logic [4:0]           rs1_r;
  logic [4:0]           rs2_r;
  logic [2:0]           inc_r;
  logic [COUNT_W-1:0]   remaining_r;
  logic                 cmd_err_r;

  logic                 accept_s;
  logic                 last_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [$clog2(DEPTH):0] fifo_level_s;
  logic [32:0]          fifo_wdata_s;
  logic [32:0]          fifo_rdata_s;

  assign cmd_ready    = (state_r == ST_IDLE);
  assign accept_s     = cmd_valid & cmd_ready;
  assign last_s       = (remaining_r == COUNT_W'(0));
  // Full is the registered level, so a same-cycle pop cannot admit a push.
  assign push_s       = (state_r == ST_EXPAND) & ~fifo_full_s;
  assign pop_s        = insn_ready & ~fifo_empty_s;
  assign fifo_wdata_s = {last_s, encode(kind_r, op_r, sew_r, rd_r, rs1_r, rs2_r)};

  assign cmd_err    = cmd_err_r;
  assign insn_valid = ~fifo_empty_s;
  assign insn       = fifo_rdata_s[31:0];
  assign insn_last  = fifo_rdata_s[32];
  assign busy       = (state_r == ST_EXPAND) | (fifo_level_s != '0);

  // Descriptor intake and burst expansion with per-field auto-increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      kind_r      <= 1'b0;
      op_r        <= 3'b000;
      sew_r       <= 2'b00;
      rd_r        <= 5'd0;
      rs1_r       <= 5'd0;
      rs2_r       <= 5'd0;
      inc_r       <= 3'b000;
      remaining_r <= COUNT_W'(0);
      cmd_err_r   <= 1'b0;
    end else begin
      cmd_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (cmd_invalid(cmd_kind, cmd_op, cmd_sew)) begin
              cmd_err_r <= 1'b1;
            end else begin
              kind_r      <= cmd_kind;
              op_r        <= cmd_op;
              sew_r       <= cmd_sew;
              rd_r        <= cmd_rd;
              rs1_r       <= cmd_rs1;
              rs2_r       <= cmd_rs2;
              inc_r       <= cmd_inc;
              remaining_r <= cmd_count;
              state_r     <= ST_EXPAND;
            end
          end
        end
        ST_EXPAND: begin
          if (push_s) begin
            if (last_s) begin
              state_r <= ST_IDLE;
            end else begin
              remaining_r <= remaining_r - COUNT_W'(1);
              if (inc_r[0]) rd_r  <= rd_r + 5'd1;
              if (inc_r[1]) rs1_r <= rs1_r + 5'd1;
              if (inc_r[2]) rs2_r <= rs2_r + 5'd1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  insn_fifo #(
    .DEPTH (DEPTH),
    .W     (33)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (fifo_wdata_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

endmodule
